bus_responder: RTL and testbench

Memory/peripheral responder on the far end of the 6502 core bus. It samples the core's `addr`/`dout`/`RW` and returns read data on `din`. It inserts wait states on RAM accesses by pulling `READY` low. It also hosts a 16-bit interval timer and an NMI edge latch that drive the core's `IRQ`/`NMI` inputs. It sits between `core` and the top level and provides RAM, vectors and interrupt sources for bring-up and test.

---
 rtl/bus_resp_pkg.sv | 42 ++++
 rtl/resp_timer.sv | 110 +++++++++++
 rtl/bus_responder.sv | 116 +++++++++++
 tb/tb_bus_responder.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_resp_pkg.sv
// Shared definitions for the 6502 bus responder: FSM states, timer register map,
// control/status bit positions and the hardware vector addresses.
package bus_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } resp_state_e;

  localparam logic [2:0]  REG_RLO  = 3'd0;
  localparam logic [2:0]  REG_RHI  = 3'd1;
  localparam logic [2:0]  REG_CTRL = 3'd2;
  localparam logic [2:0]  REG_STAT = 3'd3;
  localparam logic [2:0]  REG_CNTL = 3'd4;
  localparam logic [2:0]  REG_CNTH = 3'd5;
  localparam logic [15:0] REG_SPAN = 16'd6;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_AUTO = 2;
  localparam int STAT_TF   = 0;
  localparam int STAT_NF   = 1;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  // Byte of the vector table at address a; low byte sits at the even address.
  function automatic logic [7:0] vec_byte(input logic [15:0] a, input logic [15:0] nmi_v,
                                          input logic [15:0] rst_v, input logic [15:0] irq_v);
    logic [15:0] v;
    case ({a[15:1], 1'b0})
      VEC_NMI: v = nmi_v;
      VEC_RST: v = rst_v;
      VEC_IRQ: v = irq_v;
      default: v = 16'hFFFF;
    endcase
    return a[0] ? v[15:8] : v[7:0];
  endfunction

endpackage

// File: rtl/resp_timer.sv
// 16-bit interval timer with reload/control/status registers, plus the NMI button
// synchronizer and edge latch that feed the core's IRQ/NMI inputs.
module resp_timer
  import bus_resp_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [2:0] reg_off,
  input  logic [7:0] wdata,
  input  logic       nmi_btn,
  output logic [7:0] rdata,
  output logic       irq,
  output logic       nmi
);

  logic [15:0] reload_r, cnt_r, cnt_s;
  logic [7:0]  snap_r;
  logic        en_r, ie_r, auto_r, tf_r, nf_r;
  logic        en_s, ie_s, auto_s, tf_s, nf_s;
  logic        sync1_r, sync2_r, sync3_r;
  logic        irq_r, nmi_r;
  logic        wr_ctrl_s, wr_stat_s, expire_s, nmi_edge_s;

  // Next-state for control bits, counter and sticky flags; a set beats a same-cycle clear.
  always_comb begin
    wr_ctrl_s  = wr_en && (reg_off == REG_CTRL);
    wr_stat_s  = wr_en && (reg_off == REG_STAT);
    expire_s   = en_r && (cnt_r <= 16'd1);
    nmi_edge_s = sync2_r && !sync3_r;
    cnt_s      = cnt_r;
    if (wr_ctrl_s) begin
      en_s   = wdata[CTRL_EN];
      ie_s   = wdata[CTRL_IE];
      auto_s = wdata[CTRL_AUTO];
    end else begin
      en_s   = en_r;
      ie_s   = ie_r;
      auto_s = auto_r;
    end
    if (wr_ctrl_s && !en_r && wdata[CTRL_EN]) begin
      cnt_s = reload_r;
    end else if (expire_s) begin
      if (auto_r) begin
        cnt_s = reload_r;
      end else begin
        cnt_s = 16'd0;
        en_s  = 1'b0;
      end
    end else if (en_r) begin
      cnt_s = cnt_r - 16'd1;
    end else begin
      cnt_s = cnt_r;
    end
    tf_s = expire_s   | (tf_r & ~(wr_stat_s & wdata[STAT_TF]));
    nf_s = nmi_edge_s | (nf_r & ~(wr_stat_s & wdata[STAT_NF]));
  end

  // Register readback; the top only forwards offsets 0..5 here.
  always_comb begin
    case (reg_off)
      REG_RLO:  rdata = reload_r[7:0];
      REG_RHI:  rdata = reload_r[15:8];
      REG_CTRL: rdata = {5'd0, auto_r, ie_r, en_r};
      REG_STAT: rdata = {6'd0, nf_r, tf_r};
      REG_CNTL: rdata = cnt_r[7:0];
      REG_CNTH: rdata = snap_r;
      default:  rdata = 8'hFF;
    endcase
  end

  // Timer state, synchronizer chain and registered interrupt outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      reload_r <= 16'hFFFF;
      cnt_r    <= 16'd0;
      snap_r   <= 8'd0;
      en_r     <= 1'b0;
      ie_r     <= 1'b0;
      auto_r   <= 1'b0;
      tf_r     <= 1'b0;
      nf_r     <= 1'b0;
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      sync3_r  <= 1'b0;
      irq_r    <= 1'b0;
      nmi_r    <= 1'b0;
    end else begin
      if (wr_en && (reg_off == REG_RLO)) reload_r[7:0]  <= wdata;
      if (wr_en && (reg_off == REG_RHI)) reload_r[15:8] <= wdata;
      if (rd_en && (reg_off == REG_CNTL)) snap_r <= cnt_r[15:8];
      cnt_r   <= cnt_s;
      en_r    <= en_s;
      ie_r    <= ie_s;
      auto_r  <= auto_s;
      tf_r    <= tf_s;
      nf_r    <= nf_s;
      sync1_r <= nmi_btn;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      irq_r   <= tf_s & ie_s;
      nmi_r   <= nf_s;
    end
  end

  assign irq = irq_r;
  assign nmi = nmi_r;

endmodule

// File: rtl/bus_responder.sv
// Far-end responder on the 6502 core bus: RAM with read wait states, reset/IRQ/NMI
// vectors, and the timer/interrupt register window.
module bus_responder
  import bus_resp_pkg::*;
#(
  parameter int          RAM_AW   = 11,
  parameter int          RAM_WAIT = 1,
  parameter logic [15:0] TMR_BASE = 16'hD000,
  parameter logic [15:0] NMI_VEC  = 16'hC100,
  parameter logic [15:0] RST_VEC  = 16'hC000,
  parameter logic [15:0] IRQ_VEC  = 16'hC200
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] addr,
  input  logic [7:0]  dout,
  input  logic        RW,
  output logic [7:0]  din,
  output logic        READY,
  output logic        IRQ,
  output logic        NMI,
  input  logic        i_nmi_btn
);

  localparam int         RAM_DEPTH = 1 << RAM_AW;
  localparam logic       HAS_WAIT  = (RAM_WAIT > 0);
  localparam logic [2:0] WAIT_INIT = (RAM_WAIT > 0) ? 3'(RAM_WAIT - 1) : 3'd0;

  logic [7:0]  ram_r [0:RAM_DEPTH-1];
  resp_state_e state_r;
  logic [2:0]  wait_cnt_r;
  logic        ready_r;
  logic [7:0]  din_r;
  logic [15:0] reg_delta_s;
  logic        ram_hit_s, reg_hit_s, vec_hit_s;
  logic        ram_we_s, reg_wr_s, reg_rd_s;
  logic [7:0]  tmr_rdata_s, rd_data_s;

  // Priority decode: RAM, then timer window, then vectors, else unmapped.
  always_comb begin
    reg_delta_s = addr - TMR_BASE;
    ram_hit_s   = (addr >> RAM_AW) == 16'd0;
    reg_hit_s   = !ram_hit_s && (reg_delta_s < REG_SPAN);
    vec_hit_s   = !ram_hit_s && !reg_hit_s && (addr >= VEC_NMI);
    ram_we_s    = ready_r && !RW && ram_hit_s;
    reg_wr_s    = ready_r && !RW && reg_hit_s;
    reg_rd_s    = ready_r && RW && reg_hit_s;
    if (ram_hit_s) begin
      rd_data_s = ram_r[addr[RAM_AW-1:0]];
    end else if (reg_hit_s) begin
      rd_data_s = tmr_rdata_s;
    end else if (vec_hit_s) begin
      rd_data_s = vec_byte(addr, NMI_VEC, RST_VEC, IRQ_VEC);
    end else begin
      rd_data_s = 8'hFF;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (ram_we_s) ram_r[addr[RAM_AW-1:0]] <= dout;
  end

  // Read FSM: IDLE and DATA both sit on an access edge since READY is high there.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 3'd0;
      ready_r    <= 1'b1;
      din_r      <= 8'hFF;
    end else begin
      case (state_r)
        ST_IDLE, ST_DATA: begin
          if (RW && ram_hit_s && HAS_WAIT) begin
            state_r    <= ST_WAIT;
            wait_cnt_r <= WAIT_INIT;
            ready_r    <= 1'b0;
          end else begin
            state_r <= ST_DATA;
            if (RW) din_r <= rd_data_s;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r == 3'd0) begin
            state_r <= ST_DATA;
            ready_r <= 1'b1;
            din_r   <= rd_data_s;
          end else begin
            wait_cnt_r <= wait_cnt_r - 3'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  resp_timer u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .wr_en   (reg_wr_s),
    .rd_en   (reg_rd_s),
    .reg_off (reg_delta_s[2:0]),
    .wdata   (dout),
    .nmi_btn (i_nmi_btn),
    .rdata   (tmr_rdata_s),
    .irq     (IRQ),
    .nmi     (NMI)
  );

  assign din   = din_r;
  assign READY = ready_r;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: cycle-level reference model compared every cycle,
// plus literal expectations from the bring-up sequences.
module tb_bus_responder;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        RW;
  logic        i_nmi_btn;
  logic [7:0]  din;
  logic        READY, IRQ, NMI;
  logic [15:0] addr1;
  logic [7:0]  dout1;
  logic        rw1;
  logic        btn1 = 1'b0;
  logic [7:0]  din1;
  logic        ready1, irq1, nmi1;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  bus_responder #(.RAM_WAIT(3)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .addr(addr), .dout(dout), .RW(RW),
    .din(din), .READY(READY), .IRQ(IRQ), .NMI(NMI), .i_nmi_btn(i_nmi_btn)
  );

  bus_responder #(.RAM_WAIT(1)) u_dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .addr(addr1), .dout(dout1), .RW(rw1),
    .din(din1), .READY(ready1), .IRQ(irq1), .NMI(nmi1), .i_nmi_btn(btn1)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (RAM_WAIT = 3) ----------------
  typedef struct packed {
    logic [15:0] reload;
    logic [15:0] cnt;
    logic        en, ie, au, tf, nf;
    logic [7:0]  snap;
    logic [7:0]  din;
    logic        ready, irq, nmi;
    logic [3:0]  busy;
    logic [2:0]  hist;
  } mstate_t;

  mstate_t    m;
  logic       m_valid = 1'b0;
  logic [7:0] mmem [0:2047];

  function automatic mstate_t reset_state();
    mstate_t r;
    r = '0;
    r.reload = 16'hFFFF;
    r.din    = 8'hFF;
    r.ready  = 1'b1;
    return r;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic [15:0] a, input logic rw,
                                   input logic [7:0] d, input logic btn);
    mstate_t     n;
    logic        is_ram, is_reg, wr, tf_set;
    logic [15:0] off;
    logic [7:0]  rd;
    n      = s;
    is_ram = a < 16'h0800;
    off    = a - 16'hD000;
    is_reg = !is_ram && (off < 16'd6);
    wr     = s.ready && !rw && is_reg;
    tf_set = 1'b0;
    rd     = 8'hFF;
    if (!s.ready) begin
      n.busy = s.busy - 4'd1;
      if (n.busy == 4'd0) begin
        n.ready = 1'b1;
        n.din   = mmem[a[10:0]];
      end
    end else if (rw) begin
      if (is_ram) begin
        n.busy  = 4'd3;
        n.ready = 1'b0;
      end else begin
        if (is_reg) begin
          case (off)
            16'd0:   rd = s.reload[7:0];
            16'd1:   rd = s.reload[15:8];
            16'd2:   rd = {5'd0, s.au, s.ie, s.en};
            16'd3:   rd = {6'd0, s.nf, s.tf};
            16'd4:   rd = s.cnt[7:0];
            default: rd = s.snap;
          endcase
        end else begin
          case (a)
            16'hFFFA: rd = 8'h00;
            16'hFFFB: rd = 8'hC1;
            16'hFFFC: rd = 8'h00;
            16'hFFFD: rd = 8'hC0;
            16'hFFFE: rd = 8'h00;
            16'hFFFF: rd = 8'hC2;
            default:  rd = 8'hFF;
          endcase
        end
        n.din = rd;
        if (is_reg && off == 16'd4) n.snap = s.cnt[15:8];
      end
    end
    if (wr && off == 16'd0) n.reload[7:0]  = d;
    if (wr && off == 16'd1) n.reload[15:8] = d;
    if (wr && off == 16'd2) begin
      n.en = d[0];
      n.ie = d[1];
      n.au = d[2];
    end
    if (wr && off == 16'd2 && !s.en && d[0]) begin
      n.cnt = s.reload;
    end else if (s.en) begin
      if (s.cnt <= 16'd1) begin
        tf_set = 1'b1;
        if (s.au) n.cnt = s.reload;
        else begin
          n.cnt = 16'd0;
          n.en  = 1'b0;
        end
      end else begin
        n.cnt = s.cnt - 16'd1;
      end
    end
    n.tf   = tf_set | (s.tf & ~(wr && off == 16'd3 && d[0]));
    n.nf   = (s.hist[1] & ~s.hist[2]) | (s.nf & ~(wr && off == 16'd3 && d[1]));
    n.hist = {s.hist[1:0], btn};
    n.irq  = n.tf & n.ie;
    n.nmi  = n.nf;
    return n;
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m       <= reset_state();
      m_valid <= 1'b1;
    end else begin
      if (m.ready && !RW && addr < 16'h0800) mmem[addr[10:0]] <= dout;
      m <= step(m, addr, RW, dout, i_nmi_btn);
    end
  end

  always @(negedge i_clk) begin
    if (m_valid) begin
      check("cyc_din",   {8'd0, din},   {8'd0, m.din});
      check("cyc_ready", {15'd0, READY}, {15'd0, m.ready});
      check("cyc_irq",   {15'd0, IRQ},   {15'd0, m.irq});
      check("cyc_nmi",   {15'd0, NMI},   {15'd0, m.nmi});
    end
  end

  // ---------------- core-side driver ----------------
  task automatic access(input logic [15:0] a, input logic rw, input logic [7:0] d, output int waits);
    addr = a;
    RW   = rw;
    dout = d;
    @(posedge i_clk);
    #2;
    waits = 0;
    while (READY !== 1'b1 && waits < 16) begin
      @(posedge i_clk);
      #2;
      waits++;
    end
    if (waits >= 16) check("ready_timeout", {15'd0, READY}, 16'd1);
    addr = 16'hE000;
    RW   = 1'b1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    int w;
    access(a, 1'b0, d, w);
  endtask

  task automatic rd(input logic [15:0] a);
    int w;
    access(a, 1'b1, 8'h00, w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rd(16'hE000);
  endtask

  initial begin
    int w;
    int n;
    addr = 16'hE000; RW = 1'b1; dout = 8'h00; i_nmi_btn = 1'b0;
    addr1 = 16'hE000; rw1 = 1'b1; dout1 = 8'h00;
    #1 i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #2;
    check("rst_din",   {8'd0, din},    16'h00FF);
    check("rst_ready", {15'd0, READY}, 16'd1);
    check("rst_irq",   {15'd0, IRQ},   16'd0);
    check("rst_nmi",   {15'd0, NMI},   16'd0);
    check("rst_din1",  {8'd0, din1},   16'h00FF);
    i_rst = 1'b0;

    access(16'hFFFC, 1'b1, 8'h00, w);
    check("vec_lo", {8'd0, din}, 16'h0000);
    check("vec_lo_waits", w[15:0], 16'd0);
    rd(16'hFFFD);
    check("vec_hi", {8'd0, din}, 16'h00C0);

    wr(16'h0123, 8'h5A);
    access(16'h0123, 1'b1, 8'h00, w);
    check("ram3_low_cycles", w[15:0], 16'd3);
    check("ram3_data", {8'd0, din}, 16'h005A);

    addr1 = 16'h0123; rw1 = 1'b0; dout1 = 8'h5A;
    @(posedge i_clk); #2;
    rw1 = 1'b1;
    @(posedge i_clk); #2;
    n = 0;
    while (ready1 !== 1'b1 && n < 16) begin
      n++;
      @(posedge i_clk); #2;
    end
    check("ram1_low_cycles", n[15:0], 16'd1);
    check("ram1_data", {8'd0, din1}, 16'h005A);
    addr1 = 16'hE000;

    // periodic timer, reload 3
    wr(16'hD000, 8'h03);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h07);
    idle(1);
    check("irq_pre", {15'd0, IRQ}, 16'd0);
    idle(2);
    check("irq_expiry1", {15'd0, IRQ}, 16'd1);
    wr(16'hD003, 8'h01);
    check("irq_cleared", {15'd0, IRQ}, 16'd0);
    idle(1);
    wr(16'hD003, 8'h01);
    check("tf_set_wins", {15'd0, IRQ}, 16'd1);
    wr(16'hD002, 8'h00);
    rd(16'hD003);
    check("stat_tf", {8'd0, din}, 16'h0001);
    wr(16'hD003, 8'h01);

    // counter snapshot across a high-byte borrow
    wr(16'hD000, 8'h01);
    wr(16'hD001, 8'h12);
    wr(16'hD002, 8'h01);
    rd(16'hD004);
    check("cntl_a", {8'd0, din}, 16'h0001);
    rd(16'hD005);
    check("cnth_a", {8'd0, din}, 16'h0012);
    rd(16'hD004);
    check("cntl_b", {8'd0, din}, 16'h00FF);
    rd(16'hD005);
    check("cnth_b", {8'd0, din}, 16'h0011);
    wr(16'hD002, 8'h00);

    // one-shot, reload 2
    wr(16'hD000, 8'h02);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h03);
    idle(2);
    check("irq_oneshot", {15'd0, IRQ}, 16'd1);
    idle(2);
    rd(16'hD002);
    check("en_cleared", {8'd0, din}, 16'h0002);
    wr(16'hD003, 8'h01);
    idle(4);
    check("no_retrigger", {15'd0, IRQ}, 16'd0);
    rd(16'hD003);
    check("stat_zero", {8'd0, din}, 16'h0000);

    // reload 0 with AUTO: TF every cycle
    wr(16'hD000, 8'h00);
    wr(16'hD002, 8'h05);
    idle(1);
    wr(16'hD003, 8'h01);
    rd(16'hD003);
    check("rl0_tf", {8'd0, din}, 16'h0001);
    wr(16'hD002, 8'h00);
    wr(16'hD003, 8'h01);
    rd(16'hD003);
    check("rl0_stop", {8'd0, din}, 16'h0000);

    // NMI button
    i_nmi_btn = 1'b1;
    idle(1);
    i_nmi_btn = 1'b0;
    idle(1);
    check("nmi_early", {15'd0, NMI}, 16'd0);
    idle(1);
    check("nmi_3cyc", {15'd0, NMI}, 16'd1);
    wr(16'hD003, 8'h02);
    check("nmi_clear", {15'd0, NMI}, 16'd0);

    // reset in the middle of a waited read, with IRQ and NMI both up
    i_nmi_btn = 1'b1;
    idle(1);
    i_nmi_btn = 1'b0;
    wr(16'hD002, 8'h03);
    idle(2);
    check("irq_before_rst", {15'd0, IRQ}, 16'd1);
    check("nmi_before_rst", {15'd0, NMI}, 16'd1);
    addr = 16'h0123; RW = 1'b1;
    @(posedge i_clk); #2;
    check("wait_low", {15'd0, READY}, 16'd0);
    @(posedge i_clk); #2;
    i_rst = 1'b1;
    #1;
    check("rst_ready_async", {15'd0, READY}, 16'd1);
    check("rst_irq_async",   {15'd0, IRQ},   16'd0);
    check("rst_nmi_async",   {15'd0, NMI},   16'd0);
    @(posedge i_clk); #2;
    i_rst = 1'b0;
    addr = 16'hE000;
    rd(16'hFFFD);
    check("post_rst_vec", {8'd0, din}, 16'h00C0);
    rd(16'hE000);
    check("unmapped", {8'd0, din}, 16'h00FF);
    rd(16'hD002);
    check("ctrl_rst", {8'd0, din}, 16'h0000);
    rd(16'hD001);
    check("reload_rst", {8'd0, din}, 16'h00FF);
    access(16'h0123, 1'b1, 8'h00, w);
    check("ram_kept", {8'd0, din}, 16'h005A);
    check("ram_kept_waits", w[15:0], 16'd3);
    check("dut1_quiet", {14'd0, irq1, nmi1}, 16'd0);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
